// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and counter width.
// The state type is also used by the transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int CNT_W                = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for a single asynchronous input.
// RESET_VAL presets both stages so a line's idle level is seen straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_base.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and break recovery.
// Define UART_RX_PARITY_EN to add an even-parity bit between data bit 7 and the stop bit.
module uart_rx_base
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       Rx,
    output logic       o_active,
    output logic [7:0] o_data_byte,
    output logic       o_data_valid,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             w_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_index;
    logic [7:0]       r_shift;
    logic             r_active;
    logic [7:0]       r_data_byte;
    logic             r_data_valid;
    logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic             r_parity_bad;
    logic             r_parity_err;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_async (Rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_index  <= '0;
            r_shift      <= '0;
            r_active     <= 1'b0;
            r_data_byte  <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_cnt       <= '0;
                    r_bit_index <= '0;
                    r_active    <= 1'b0;
                    if (!w_rx_s) begin
                        r_state  <= START;
                        r_active <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                        end else begin
                            // Start bit did not survive to mid-period: treat as a glitch.
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt                <= '0;
                        r_shift[r_bit_index] <= w_rx_s;
                        if (r_bit_index == 3'd7) begin
                            r_bit_index <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state     <= PARITY;
`else
                            r_state     <= STOP;
`endif
                        end else begin
                            r_bit_index <= r_bit_index + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt        <= '0;
                        r_parity_bad <= w_rx_s ^ (^r_shift);
                        r_state      <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (r_parity_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_data_byte  <= r_shift;
                                r_data_valid <= 1'b1;
                            end
`else
                            r_data_byte  <= r_shift;
                            r_data_valid <= 1'b1;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    // Hold off until the line returns high so a break yields only one error.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_active     = r_active;
    assign o_data_byte  = r_data_byte;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
